// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch with credit-limited buffer and branch/jump redirect
module fetch_unit #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_base,
  input  logic [XLEN-1:0] redirect_imm,
  input  logic            redirect_jalr,
  output logic            misaligned
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [XLEN-1:0] fetch_pc, rsp_pc, target;
  logic [CW-1:0] outstanding, drop_cnt, count, out_next;
  logic [CW:0] used;
  logic [AW-1:0] head, tail;
  logic [31:0] buf_instr [DEPTH];
  logic [XLEN-1:0] buf_pc [DEPTH];
  logic req_fire, push, pop;
  assign used = {1'b0, outstanding} + {1'b0, count};
  assign imem_req_valid = rst_n && used < (CW+1)'(DEPTH) && !redirect_valid;
  assign imem_req_addr = fetch_pc;
  assign req_fire = imem_req_valid && imem_req_ready;
  assign push = imem_rsp_valid && drop_cnt == '0 && !redirect_valid;
  assign pop = id_valid && id_ready && !redirect_valid;
  assign out_next = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
  assign target = (redirect_base + redirect_imm) & ~XLEN'(redirect_jalr);
  assign id_valid = count != '0;
  assign id_instr = buf_instr[head];
  assign id_pc = buf_pc[head];
  // PCs, credit counters, buffer pointers; a redirect flushes and marks in-flight responses stale
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      rsp_pc <= RESET_PC;
      outstanding <= '0;
      drop_cnt <= '0;
      count <= '0;
      head <= '0;
      tail <= '0;
      misaligned <= 1'b0;
    end else begin
      outstanding <= out_next;
      misaligned <= redirect_valid && target[1];
      if (redirect_valid) begin
        fetch_pc <= target;
        rsp_pc <= target;
        drop_cnt <= out_next;
        count <= '0;
        head <= '0;
        tail <= '0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
        if (imem_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
        if (push) rsp_pc <= rsp_pc + XLEN'(4);
        if (push) tail <= tail + AW'(1);
        if (pop) head <= head + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  // instruction/PC storage written at the tail on every accepted response
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_instr[i] <= '0;
        buf_pc[i] <= '0;
      end
    end else if (push) begin
      buf_instr[tail] <= imem_rsp_data;
      buf_pc[tail] <= rsp_pc;
    end
  // the credit rule must keep pushes away from a full buffer
  always_ff @(posedge clk)
    if (rst_n && push) assert (count != CW'(DEPTH));
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed plus random fetch traffic checked against an epoch-tagged memory/buffer model
module tb_fetch_unit;
  localparam int DEPTH = 2;
  typedef struct { logic [31:0] addr; int epoch; int due; } req_t;
  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;
  logic mr, rsp_v, ir, rv, rj;
  logic [31:0] rsp_d, rb, ri;
  logic req_v, id_v, mis;
  logic [31:0] req_a, id_i, id_p;
  logic w_req_v, w_id_v, w_mis;
  logic [31:0] w_req_a, w_id_i, w_id_p;
  req_t mem_q[$];
  logic [31:0] bq[$];
  logic [31:0] exp_fetch;
  int epoch, cyc, lat, checks, failures;
  bit rsp_en, post_redir, exp_mis;
  logic w_rv_s;
  logic [31:0] w_a_s;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(req_v), .imem_req_ready(mr), .imem_req_addr(req_a),
    .imem_rsp_valid(rsp_v), .imem_rsp_data(rsp_d),
    .id_valid(id_v), .id_ready(ir), .id_instr(id_i), .id_pc(id_p),
    .redirect_valid(rv), .redirect_base(rb), .redirect_imm(ri), .redirect_jalr(rj),
    .misaligned(mis)
  );

  fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .DEPTH(DEPTH)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(w_req_v), .imem_req_ready(1'b1), .imem_req_addr(w_req_a),
    .imem_rsp_valid(1'b0), .imem_rsp_data(32'h0),
    .id_valid(w_id_v), .id_ready(1'b0), .id_instr(w_id_i), .id_pc(w_id_p),
    .redirect_valid(1'b0), .redirect_base(32'h0), .redirect_imm(32'h0), .redirect_jalr(1'b0),
    .misaligned(w_mis)
  );

  function automatic logic [31:0] f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      logic [31:0] t;
      bit exp_rv, do_pop;
      req_t r;
      rsp_v = rsp_en && mem_q.size() > 0 && mem_q[0].due <= cyc;
      rsp_d = rsp_v ? f(mem_q[0].addr) : $urandom;
      #1;
      exp_rv = (mem_q.size() + bq.size() < DEPTH) && !rv;
      chk("req_valid", req_v, exp_rv);
      if (exp_rv) chk("req_addr", req_a, exp_fetch);
      chk("id_valid", id_v, bq.size() != 0);
      if (bq.size() != 0) begin
        chk("id_pc", id_p, bq[0]);
        chk("id_instr", id_i, f(bq[0]));
      end
      chk("misaligned", mis, post_redir && exp_mis);
      w_rv_s = w_req_v;
      w_a_s = w_req_a;
      @(posedge clk);
      do_pop = !rv && bq.size() != 0 && ir;
      if (rsp_v) begin
        r = mem_q.pop_front();
        if (!rv && r.epoch == epoch) bq.push_back(r.addr);
      end
      if (do_pop) void'(bq.pop_front());
      if (exp_rv && mr) begin
        r.addr = exp_fetch;
        r.epoch = epoch;
        r.due = cyc + lat;
        mem_q.push_back(r);
        exp_fetch += 4;
      end
      post_redir = rv;
      if (rv) begin
        t = rb + ri;
        if (rj) t[0] = 1'b0;
        exp_fetch = t;
        exp_mis = t[1];
        bq.delete();
        epoch++;
      end
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic redirect(input logic [31:0] base, input logic [31:0] imm, input logic jalr);
    rv = 1; rb = base; ri = imm; rj = jalr;
    tick(1);
    rv = 0;
    tick(1);
  endtask

  initial begin
    mr = 0; ir = 0; rv = 0; rj = 0; rb = 0; ri = 0; rsp_v = 0; rsp_d = 0;
    rsp_en = 1; lat = 1; exp_fetch = 32'h0; epoch = 0; cyc = 0;
    checks = 0; failures = 0; post_redir = 0; exp_mis = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_valid", req_v, 0);
    chk("rst_id_valid", id_v, 0);
    chk("rst_misaligned", mis, 0);
    chk("rst_wrap_req_valid", w_req_v, 0);
    @(negedge clk);
    rst_n = 1;
    mr = 1; ir = 1;
    tick(1);
    chk("wrap_first_valid", w_rv_s, 1);
    chk("wrap_first_addr", w_a_s, 32'hFFFF_FFFC);
    tick(1);
    chk("wrap_second_valid", w_rv_s, 1);
    chk("wrap_second_addr", w_a_s, 32'h0000_0000);
    tick(1);
    chk("wrap_credit_stop", w_rv_s, 0);
    tick(17);
    ir = 0;
    tick(10);
    ir = 1;
    tick(10);
    lat = 6;
    tick(3);
    redirect(32'h0000_0100, 32'hFFFF_FFF0, 0);
    lat = 1;
    tick(10);
    redirect(32'h0000_2001, 32'h0000_0004, 1);
    tick(6);
    redirect(32'h0000_2002, 32'h0000_0000, 0);
    tick(6);
    rv = 1; rb = 32'h0000_0400; ri = 32'h0000_0010; rj = 0;
    tick(1);
    rb = 32'h0000_0800; ri = 32'h0000_0022;
    tick(1);
    rv = 0;
    tick(8);
    ir = 0; lat = 3;
    tick(6);
    rst_n = 0;
    rsp_v = 0;
    #1;
    chk("midrst_req_valid", req_v, 0);
    chk("midrst_id_valid", id_v, 0);
    chk("midrst_id_pc", id_p, 0);
    chk("midrst_id_instr", id_i, 0);
    chk("midrst_misaligned", mis, 0);
    mem_q.delete();
    bq.delete();
    exp_fetch = 32'h0;
    post_redir = 0;
    @(negedge clk);
    rst_n = 1;
    ir = 1; lat = 1;
    tick(1);
    chk("midrst_wrap_restart", w_a_s, 32'hFFFF_FFFC);
    tick(9);
    for (int n = 0; n < 3000; n++) begin
      mr = $urandom_range(0, 3) != 0;
      ir = $urandom_range(0, 2) != 0;
      rsp_en = $urandom_range(0, 3) != 0;
      lat = $urandom_range(1, 4);
      rv = $urandom_range(0, 15) == 0;
      rb = $urandom_range(0, 1) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      ri = $urandom_range(0, 1) ? ($urandom_range(0, 4095) - 2048) : $urandom;
      rj = $urandom_range(0, 1);
      tick(1);
    end
    rv = 0; rsp_en = 1; mr = 1; ir = 1;
    tick(8);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
